// File: rtl/scoreboard_reg_bank.sv
// Register bank with per-register busy scoreboard, two combinational read
// ports, one write port and same-cycle write-to-read forwarding.
module scoreboard_reg_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [ADDR_WIDTH-1:0] regA,
  input  logic [ADDR_WIDTH-1:0] regB,
  output logic [DATA_WIDTH-1:0] dataA,
  output logic [DATA_WIDTH-1:0] dataB,
  output logic                  readyA,
  output logic                  readyB,
  input  logic                  writeFlag,
  input  logic [ADDR_WIDTH-1:0] regC,
  input  logic [DATA_WIDTH-1:0] dataWrite,
  input  logic                  issueFlag,
  input  logic [ADDR_WIDTH-1:0] issueReg,
  output logic                  issueAck,
  output logic [ADDR_WIDTH:0]   pendingCount
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [CW-1:0]         r_pending;

  logic             w_wr_en;
  logic             w_issue_ack;
  logic             w_set;
  logic             w_clr;
  logic [DEPTH-1:0] w_busy_next;
  logic             w_fwd_a;
  logic             w_fwd_b;

  // Writes to a hardwired-zero register 0 are dropped entirely.
  assign w_wr_en = writeFlag && !(ZERO_REG && (regC == '0));

  // A pending write to the same register retires the old reservation, so a
  // busy register can be re-reserved in that cycle. Nothing is accepted in reset.
  assign w_issue_ack = resetN && issueFlag &&
                       (!r_busy[issueReg] || (writeFlag && (regC == issueReg)));

  assign w_set = w_issue_ack && !(ZERO_REG && (issueReg == '0));
  assign w_clr = w_wr_en && r_busy[regC];

  always_comb begin
    // NOTE: default assigned first so every path drives w_busy_next (no latch).
    w_busy_next = r_busy;
    if (w_wr_en)
      w_busy_next[regC] = 1'b0;
    // Set after clear: a new reservation on the written register wins.
    if (w_set)
      w_busy_next[issueReg] = 1'b1;
  end

  // NOTE: the data array is reset too, since reset must read back all zeros.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
    end else if (w_wr_en) begin
      // NOTE: non-blocking for all sequential state.
      r_regs[regC] <= dataWrite;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      r_busy <= w_busy_next;
      // Set and clear in the same cycle leave the population unchanged.
      unique case ({w_set, w_clr})
        2'b10:   r_pending <= r_pending + CW'(1);
        2'b01:   r_pending <= r_pending - CW'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign w_fwd_a = BYPASS && resetN && w_wr_en && (regC == regA);
  assign w_fwd_b = BYPASS && resetN && w_wr_en && (regC == regB);

  assign dataA = w_fwd_a ? dataWrite :
                 (ZERO_REG && (regA == '0)) ? '0 : r_regs[regA];
  assign dataB = w_fwd_b ? dataWrite :
                 (ZERO_REG && (regB == '0)) ? '0 : r_regs[regB];

  assign readyA = !r_busy[regA] || (ZERO_REG && (regA == '0)) ||
                  (BYPASS && resetN && writeFlag && (regC == regA));
  assign readyB = !r_busy[regB] || (ZERO_REG && (regB == '0)) ||
                  (BYPASS && resetN && writeFlag && (regC == regB));

  assign issueAck     = w_issue_ack;
  assign pendingCount = r_pending;

endmodule

// File: tb/tb_scoreboard_reg_bank.sv
// Directed bench for scoreboard_reg_bank: a forwarding instance and a
// non-forwarding instance share the same stimulus.
module tb_scoreboard_reg_bank;

  logic        clock = 1'b0;
  logic        resetN;
  logic [4:0]  regA, regB, regC, issueReg;
  logic        writeFlag, issueFlag;
  logic [31:0] dataWrite;

  logic [31:0] dataA, dataB, nb_dataA, nb_dataB;
  logic        readyA, readyB, nb_readyA, nb_readyB;
  logic        issueAck, nb_issueAck;
  logic [5:0]  pendingCount, nb_pendingCount;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  scoreboard_reg_bank dut (
    .clock(clock), .resetN(resetN), .regA(regA), .regB(regB),
    .dataA(dataA), .dataB(dataB), .readyA(readyA), .readyB(readyB),
    .writeFlag(writeFlag), .regC(regC), .dataWrite(dataWrite),
    .issueFlag(issueFlag), .issueReg(issueReg), .issueAck(issueAck),
    .pendingCount(pendingCount)
  );

  scoreboard_reg_bank #(.BYPASS(1'b0)) dut_nb (
    .clock(clock), .resetN(resetN), .regA(regA), .regB(regB),
    .dataA(nb_dataA), .dataB(nb_dataB), .readyA(nb_readyA), .readyB(nb_readyB),
    .writeFlag(writeFlag), .regC(regC), .dataWrite(dataWrite),
    .issueFlag(issueFlag), .issueReg(issueReg), .issueAck(nb_issueAck),
    .pendingCount(nb_pendingCount)
  );

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 2 time units after the rising edge, well clear of it.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    writeFlag = 1'b0;
    issueFlag = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; regA = '0; regB = '0; regC = '0; issueReg = '0;
    writeFlag = 1'b0; issueFlag = 1'b0; dataWrite = '0;
    regA = 5'd5; regB = 5'd7;
    #3;
    check("reset_dataA", dataA, 0);
    check("reset_readyA", readyA, 1);
    check("reset_count", pendingCount, 0);
    tick();
    resetN = 1'b1;

    // Plain write then read.
    writeFlag = 1'b1; regC = 5'd5; dataWrite = 32'hDEADBEEF;
    tick();
    idle(); regA = 5'd5;
    #1;
    check("wr_r5_dataA", dataA, 32'hDEADBEEF);
    check("wr_r5_readyA", readyA, 1);

    // Forwarding versus no forwarding.
    writeFlag = 1'b1; regC = 5'd7; dataWrite = 32'h11111111;
    tick();
    writeFlag = 1'b1; regC = 5'd7; dataWrite = 32'h12345678; regB = 5'd7;
    #1;
    check("bypass_dataB", dataB, 32'h12345678);
    check("nobypass_dataB", nb_dataB, 32'h11111111);
    tick();
    idle();
    #1;
    check("nobypass_after_dataB", nb_dataB, 32'h12345678);

    // Issue, re-issue refused, write retires.
    issueFlag = 1'b1; issueReg = 5'd3;
    #1;
    check("issue_r3_ack", issueAck, 1);
    tick();
    idle(); regA = 5'd3;
    #1;
    check("r3_busy_readyA", readyA, 0);
    check("r3_count1", pendingCount, 1);
    issueFlag = 1'b1; issueReg = 5'd3;
    #1;
    check("reissue_r3_ack", issueAck, 0);
    tick();
    idle();
    #1;
    check("reissue_count", pendingCount, 1);
    writeFlag = 1'b1; regC = 5'd3; dataWrite = 32'h00000033;
    #1;
    check("r3_fwd_readyA", readyA, 1);
    check("r3_nofwd_readyA", nb_readyA, 0);
    tick();
    idle();
    #1;
    check("r3_done_readyA", readyA, 1);
    check("r3_done_count", pendingCount, 0);
    check("r3_done_dataA", dataA, 32'h33);

    // Register 0 is hardwired.
    writeFlag = 1'b1; regC = 5'd0; dataWrite = 32'hFFFFFFFF;
    issueFlag = 1'b1; issueReg = 5'd0; regA = 5'd0;
    #1;
    check("r0_ack", issueAck, 1);
    check("r0_dataA_same", dataA, 0);
    tick();
    idle();
    #1;
    check("r0_dataA", dataA, 0);
    check("r0_readyA", readyA, 1);
    check("r0_count", pendingCount, 0);

    // Same-cycle write and re-issue on a busy register.
    issueFlag = 1'b1; issueReg = 5'd4;
    tick();
    idle();
    #1;
    check("r4_count1", pendingCount, 1);
    writeFlag = 1'b1; regC = 5'd4; dataWrite = 32'h0000ABCD;
    issueFlag = 1'b1; issueReg = 5'd4;
    #1;
    check("r4_reissue_ack", issueAck, 1);
    tick();
    idle(); regA = 5'd4;
    #1;
    check("r4_still_busy", readyA, 0);
    check("r4_count_same", pendingCount, 1);
    check("r4_data", dataA, 32'hABCD);

    // Build up reservations, then an unclocked reset drops everything.
    issueFlag = 1'b1; issueReg = 5'd1;
    tick();
    issueFlag = 1'b1; issueReg = 5'd2;
    tick();
    idle();
    writeFlag = 1'b1; regC = 5'd9; dataWrite = 32'h000000A5;
    tick();
    idle(); regA = 5'd9; regB = 5'd1;
    #1;
    check("pre_reset_r9", dataA, 32'hA5);
    check("pre_reset_count", pendingCount, 3);
    check("pre_reset_readyB", readyB, 0);
    resetN = 1'b0;
    #1;
    check("async_reset_dataA", dataA, 0);
    check("async_reset_count", pendingCount, 0);
    check("async_reset_readyB", readyB, 1);
    regA = 5'd5; regB = 5'd2;
    #1;
    check("async_reset_r5", dataA, 0);
    check("async_reset_readyB_r2", readyB, 1);
    issueFlag = 1'b1; issueReg = 5'd6;
    writeFlag = 1'b1; regC = 5'd5; dataWrite = 32'h5555AAAA;
    tick();
    idle();
    #1;
    check("in_reset_write_ignored", dataA, 0);
    check("in_reset_count", pendingCount, 0);
    resetN = 1'b1;

    // Operation resumes after reset.
    issueFlag = 1'b1; issueReg = 5'd1;
    #1;
    check("resume_ack", issueAck, 1);
    tick();
    idle();
    #1;
    check("resume_count", pendingCount, 1);
    check("resume_nb_count", nb_pendingCount, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard_reg_bank.md
SCOREBOARD_REG_BANK -- requirements
Module: scoreboard_reg_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the register and data-port width.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the register address width; depth SHALL be 2**ADDR_WIDTH.
REQ-003 Parameter ZERO_REG, default 1, SHALL hardwire register 0 to zero when 1.
REQ-004 Parameter BYPASS, default 1, SHALL enable same-cycle write-to-read forwarding when 1.
REQ-005 Ports SHALL be, in order:
- clock  in  1  sole clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- regA  in  ADDR_WIDTH  read address, port A.
- regB  in  ADDR_WIDTH  read address, port B.
- dataA  out  DATA_WIDTH  read data, port A.
- dataB  out  DATA_WIDTH  read data, port B.
- readyA  out  1  port A register has no pending write.
- readyB  out  1  port B register has no pending write.
- writeFlag  in  1  write enable.
- regC  in  ADDR_WIDTH  write address.
- dataWrite  in  DATA_WIDTH  write data.
- issueFlag  in  1  reserve request for issueReg.
- issueReg  in  ADDR_WIDTH  register to reserve.
- issueAck  out  1  reservation accepted this cycle.
- pendingCount  out  ADDR_WIDTH+1  number of busy registers.

Function
REQ-006 Write: on rising clock with writeFlag=1, registers[regC] SHALL take dataWrite; ignored when ZERO_REG=1 and regC=0.
REQ-007 Read: dataA/dataB SHALL be combinational: registers[regA]/registers[regB]; 0 when ZERO_REG=1 and address 0.
REQ-008 Bypass: with BYPASS=1, writeFlag=1, regC equal to the read address and the write not ignored per REQ-006, that read port SHALL output dataWrite in the same cycle.
REQ-009 Scoreboard: one busy bit per register; all bits SHALL be 0 after reset.
REQ-010 issueAck SHALL be combinational: issueFlag AND (busy[issueReg]=0 OR (writeFlag=1 AND regC=issueReg)).
REQ-011 Accepted issue SHALL set busy[issueReg] at the next rising clock; a refused issue (issueAck=0) SHALL change no state.
REQ-012 Write SHALL clear busy[regC] at the rising clock; a write to a non-busy register SHALL update data only.
REQ-013 Simultaneous accepted issue and write to the same register: busy SHALL end set (new reservation wins), data SHALL be written.
REQ-014 With ZERO_REG=1, register 0 SHALL never become busy; issueReg=0 SHALL give issueAck=issueFlag without state change; readyA/readyB SHALL be 1 for address 0.
REQ-015 readyA SHALL equal NOT busy[regA], OR'd with (writeFlag AND regC=regA) when BYPASS=1; readyB likewise.
REQ-016 pendingCount SHALL equal the population count of busy bits, updated at the rising clock: +1 on a set-only, -1 on a clear-only, unchanged when both or neither occur.
REQ-017 pendingCount SHALL never exceed 2**ADDR_WIDTH (2**ADDR_WIDTH-1 with ZERO_REG=1) nor underflow below 0.

Reset
REQ-018 resetN=0 SHALL immediately, without clock, clear all registers, all busy bits and pendingCount to 0; dataA/dataB read 0, readyA/readyB read 1.
REQ-019 Writes and issues SHALL be ignored while resetN=0; operation SHALL resume on the first rising clock after resetN=1, and a reset mid-reservation SHALL drop all reservations.

Verification
REQ-020 Bench SHALL cover:
- Write 0xDEADBEEF to r5, next cycle regA=5 -> dataA=0xDEADBEEF, readyA=1.
- writeFlag=1, regC=7, dataWrite=0x12345678, regB=7, BYPASS=1 -> dataB=0x12345678 same cycle; BYPASS=0 -> old value.
- Issue r3 (ack=1), regA=3 -> readyA=0, pendingCount=1; re-issue r3 -> ack=0, count stays 1; write r3 -> readyA=1, count=0.
- Write r0=0xFFFFFFFF and issue r0 with ZERO_REG=1 -> dataA=0 at regA=0, readyA=1, pendingCount=0, issueAck=1.
- r4 busy; same cycle write r4 and issue r4 -> ack=1, busy stays set, data updated, count unchanged.
- Issue r1,r2, write r9=0xA5, assert resetN=0 between clocks -> all data 0, count 0, ready 1 immediately.
